if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_pkg.sv | 13 +
 rtl/if_id_stage.sv | 139 +++++++++++++
 tb/tb_if_id_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// Shared types and defaults for the fetch/decode pipeline register.
package if_id_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } if_id_state_e;

  localparam logic [31:0] NopInstDefault = 32'h0000_0013;
  localparam int unsigned CntWDefault    = 8;

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: two-entry skid buffer between fetch and decode, with
// flush and a saturating flush statistics counter.
module if_id_stage
  import if_id_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INST = NopInstDefault,
  parameter int unsigned CNT_W    = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_addr,
  output logic [31:0]      out_inst,
  output logic [CNT_W-1:0] flush_cnt
);

  if_id_state_e     state_q, state_d;
  logic [XLEN-1:0]  main_addr_q, main_addr_d;
  logic [31:0]      main_inst_q, main_inst_d;
  logic [XLEN-1:0]  skid_addr_q, skid_addr_d;
  logic [31:0]      skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             in_fire, out_fire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides any transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (in_fire) state_d = StOne;
      StOne: begin
        if (in_fire && !out_fire) begin
          state_d = StFull;
        end else if (out_fire && !in_fire) begin
          state_d = StEmpty;
        end
      end
      StFull:  if (out_fire) state_d = StOne;
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  // Outputs depend on state only, so in_ready has no path from out_ready
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    out_addr  = out_valid ? main_addr_q : '0;
    out_inst  = out_valid ? main_inst_q : NOP_INST;
    flush_cnt = flush_cnt_q;
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Entry datapath
  always_comb begin
    main_addr_d = main_addr_q;
    main_inst_d = main_inst_q;
    skid_addr_d = skid_addr_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      main_addr_d = '0;
      main_inst_d = NOP_INST;
      skid_addr_d = '0;
      skid_inst_d = NOP_INST;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_addr_d = in_addr;
            main_inst_d = in_inst;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_addr_d = in_addr;
            main_inst_d = in_inst;
          end else if (in_fire) begin
            skid_addr_d = in_addr;
            skid_inst_d = in_inst;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_addr_d = skid_addr_q;
            main_inst_d = skid_inst_q;
            skid_addr_d = '0;
            skid_inst_d = NOP_INST;
          end
        end
        default: begin
          main_addr_d = '0;
          main_inst_d = NOP_INST;
        end
      endcase
    end
  end

  // Only flushes that actually discard something are counted
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && (state_q != StEmpty) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_addr_q <= '0;
      main_inst_q <= NOP_INST;
      skid_addr_q <= '0;
      skid_inst_q <= NOP_INST;
      flush_cnt_q <= '0;
    end else begin
      main_addr_q <= main_addr_d;
      main_inst_q <= main_inst_d;
      skid_addr_q <= skid_addr_d;
      skid_inst_q <= skid_inst_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: queue-based reference model, per-cycle
// compare, directed scenarios and a randomized phase.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_addr, out_inst;
  logic [7:0]  flush_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_addr, s_out_inst;
  logic [1:0]  s_flush_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_inst   (in_inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_inst  (out_inst),
    .flush_cnt (flush_cnt)
  );

  if_id_stage #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_addr   (in_addr),
    .in_inst   (in_inst),
    .flush     (flush),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_addr  (s_out_addr),
    .out_inst  (s_out_inst),
    .flush_cnt (s_flush_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue holding at most two entries
  logic [31:0] m_addr[$];
  logic [31:0] m_inst[$];
  int unsigned m_flushes;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr.delete();
      m_inst.delete();
      m_flushes = 0;
    end else begin
      bit acc, del;
      acc = in_valid && (m_addr.size() < 2);
      del = (m_addr.size() > 0) && out_ready;
      if (flush) begin
        if (m_addr.size() > 0) m_flushes++;
        m_addr.delete();
        m_inst.delete();
      end else begin
        if (del) begin
          void'(m_addr.pop_front());
          void'(m_inst.pop_front());
        end
        if (acc) begin
          m_addr.push_back(in_addr);
          m_inst.push_back(in_inst);
        end
      end
    end
  end

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ea, ei;
    ev = (m_addr.size() > 0);
    ea = ev ? m_addr[0] : 32'h0;
    ei = ev ? m_inst[0] : Nop;
    check("out_valid", {63'h0, out_valid}, {63'h0, ev});
    check("out_addr", {32'h0, out_addr}, {32'h0, ea});
    check("out_inst", {32'h0, out_inst}, {32'h0, ei});
    check("in_ready", {63'h0, in_ready}, {63'h0, m_addr.size() < 2});
    check("flush_cnt", {56'h0, flush_cnt}, 64'(sat(m_flushes, 255)));
    check("sat_out_addr", {32'h0, s_out_addr}, {32'h0, ea});
    check("sat_flush_cnt", {62'h0, s_flush_cnt}, 64'(sat(m_flushes, 3)));
  end

  task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] i,
                      input logic fl, input logic ordy);
    in_valid  = v;
    in_addr   = a;
    in_inst   = i;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sat_exp[4] = '{1, 2, 3, 3};
    rst_n = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_out_inst", {32'h0, out_inst}, 64'h13);
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);
    check("rst_flush_cnt", {56'h0, flush_cnt}, 64'd0);
    rst_n = 1'b1;

    // Streaming
    tick(1'b1, 32'h0, 32'hA000_0001, 1'b0, 1'b1);
    check("stream_a0", {32'h0, out_addr}, 64'h0);
    check("stream_i0", {32'h0, out_inst}, 64'hA000_0001);
    tick(1'b1, 32'h4, 32'hA000_0002, 1'b0, 1'b1);
    check("stream_a1", {32'h0, out_addr}, 64'h4);
    tick(1'b1, 32'h8, 32'hA000_0003, 1'b0, 1'b1);
    check("stream_a2", {32'h0, out_addr}, 64'h8);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("stream_drain", {63'h0, out_valid}, 64'd0);

    // Stall then release
    tick(1'b1, 32'h10, 32'hB000_000A, 1'b0, 1'b0);
    check("stall_rdy1", {63'h0, in_ready}, 64'd1);
    tick(1'b1, 32'h14, 32'hB000_000B, 1'b0, 1'b0);
    check("stall_rdy0", {63'h0, in_ready}, 64'd0);
    check("stall_head", {32'h0, out_addr}, 64'h10);
    check("model_depth", 64'(m_addr.size()), 64'd2);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("stall_hold", {32'h0, out_addr}, 64'h10);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("release_head", {32'h0, out_addr}, 64'h14);
    check("release_rdy", {63'h0, in_ready}, 64'd1);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("release_empty", {63'h0, out_valid}, 64'd0);

    // Flush in FULL with a third pair offered
    tick(1'b1, 32'h10, 32'hB000_000A, 1'b0, 1'b0);
    tick(1'b1, 32'h14, 32'hB000_000B, 1'b0, 1'b0);
    tick(1'b1, 32'h18, 32'hC000_000C, 1'b1, 1'b0);
    check("flush_valid", {63'h0, out_valid}, 64'd0);
    check("flush_inst", {32'h0, out_inst}, 64'h13);
    check("flush_cnt1", {56'h0, flush_cnt}, 64'd1);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("flush_no_c", {63'h0, out_valid}, 64'd0);

    // Asynchronous reset while FULL
    tick(1'b1, 32'h20, 32'hD000_0000, 1'b0, 1'b0);
    tick(1'b1, 32'h24, 32'hD000_0001, 1'b0, 1'b0);
    check("pre_arst_valid", {63'h0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {63'h0, out_valid}, 64'd0);
    check("arst_ready", {63'h0, in_ready}, 64'd1);
    check("arst_cnt", {56'h0, flush_cnt}, 64'd0);
    #1 rst_n = 1'b1;

    // Saturation on the 2-bit counter
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 32'h100 + 32'(4 * k), 32'hE000_0000 + 32'(k), 1'b0, 1'b0);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("sat_cnt", {62'h0, s_flush_cnt}, 64'(sat_exp[k]));
      check("wide_cnt", {56'h0, flush_cnt}, 64'(k + 1));
    end
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("sat_empty_flush", {62'h0, s_flush_cnt}, 64'd3);
    check("wide_empty_flush", {56'h0, flush_cnt}, 64'd4);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tick($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, $urandom,
           $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6);
    end
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
